// File: rtl/lcd_timing_pkg.sv
// Shared timing presets, polarity constants and helpers for the LCD raster
// timing generator.
package lcd_timing_pkg;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  // 480x272 panel
  localparam int unsigned LCD480_H_ACTIVE = 480;
  localparam int unsigned LCD480_H_FP     = 2;
  localparam int unsigned LCD480_H_SYNC   = 41;
  localparam int unsigned LCD480_H_BP     = 2;
  localparam int unsigned LCD480_V_ACTIVE = 272;
  localparam int unsigned LCD480_V_FP     = 2;
  localparam int unsigned LCD480_V_SYNC   = 10;
  localparam int unsigned LCD480_V_BP     = 2;

  // 800x480 panel
  localparam int unsigned LCD800_H_ACTIVE = 800;
  localparam int unsigned LCD800_H_FP     = 210;
  localparam int unsigned LCD800_H_SYNC   = 20;
  localparam int unsigned LCD800_H_BP     = 46;
  localparam int unsigned LCD800_V_ACTIVE = 480;
  localparam int unsigned LCD800_V_FP     = 22;
  localparam int unsigned LCD800_V_SYNC   = 10;
  localparam int unsigned LCD800_V_BP     = 23;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic sof;
  } sync_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lcd_timing_gen_sync_delay.sv
// Fixed-depth shift register for the 4-bit sync bundle; clock-enabled,
// async reset to a configurable idle vector, wire when DEPTH is 0.
module sync_delay
  import lcd_timing_pkg::*;
#(
  parameter int unsigned DEPTH   = 0,
  parameter sync_t       RST_VAL = '0
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  en_i,
  input  sync_t din_i,
  output sync_t dout_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk_i, rst_i, en_i};
    assign dout_o        = din_i;
  end else begin : g_pipe
    sync_t stage_q [DEPTH];
    sync_t stage_d [DEPTH];

    always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i];
      end
      if (en_i) begin
        stage_d[0] = din_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for parallel RGB LCD panels: pixel-clock counters,
// region decode, registered outputs and optional sync/DE re-alignment delay.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = LCD480_H_ACTIVE,
  parameter int unsigned H_FP     = LCD480_H_FP,
  parameter int unsigned H_SYNC   = LCD480_H_SYNC,
  parameter int unsigned H_BP     = LCD480_H_BP,
  parameter int unsigned V_ACTIVE = LCD480_V_ACTIVE,
  parameter int unsigned V_FP     = LCD480_V_FP,
  parameter int unsigned V_SYNC   = LCD480_V_SYNC,
  parameter int unsigned V_BP     = LCD480_V_BP,
  parameter bit          HS_POL   = POL_LOW,
  parameter bit          VS_POL   = POL_LOW,
  parameter int unsigned PIPE_DLY = 0,
  parameter int unsigned COL_W    = 9,
  parameter int unsigned LIN_W    = 9
) (
  input  logic             pxclk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [COL_W-1:0] col_o,
  output logic [LIN_W-1:0] lin_o,
  output logic             sof_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W    = clog2(H_TOTAL);
  localparam int unsigned VC_W    = clog2(V_TOTAL);

  localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT_END  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_SYNC_BEG = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT_END  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_SYNC_BEG = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam sync_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, de: 1'b0, sof: 1'b0};

  if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_chk_active
    $error("lcd_timing_gen: H_ACTIVE and V_ACTIVE must be >= 1");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_chk_hporch
    $error("lcd_timing_gen: H_FP, H_SYNC and H_BP must be >= 1");
  end
  if (V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_vporch
    $error("lcd_timing_gen: V_FP, V_SYNC and V_BP must be >= 1");
  end
  if (PIPE_DLY > 15) begin : g_chk_dly
    $error("lcd_timing_gen: PIPE_DLY must be <= 15");
  end
  if ((64'd1 << COL_W) < 64'(H_ACTIVE) || (64'd1 << LIN_W) < 64'(V_ACTIVE)) begin : g_chk_coord
    $error("lcd_timing_gen: COL_W/LIN_W too narrow for the active area");
  end

  logic [HC_W-1:0]  hcnt_q, hcnt_d;
  logic [VC_W-1:0]  vcnt_q, vcnt_d;
  sync_t            sync_q, sync_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [LIN_W-1:0] lin_q, lin_d;
  sync_t            sync_dly;

  logic hactive, vactive, hsync_act, vsync_act;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (en_i) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  // Vertical regions change only on the line wrap, so vsync edges land on hcnt=0.
  always_comb begin
    hactive   = hcnt_q < H_ACT_END;
    vactive   = vcnt_q < V_ACT_END;
    hsync_act = (hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END);
    vsync_act = (vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END);
  end

  always_comb begin
    sync_d = sync_q;
    col_d  = col_q;
    lin_d  = lin_q;
    if (en_i) begin
      sync_d.hsync = hsync_act ? HS_POL : ~HS_POL;
      sync_d.vsync = vsync_act ? VS_POL : ~VS_POL;
      sync_d.de    = hactive & vactive;
      sync_d.sof   = (hcnt_q == '0) && (vcnt_q == '0);
      col_d        = (hactive & vactive) ? COL_W'(hcnt_q) : '0;
      lin_d        = (hactive & vactive) ? LIN_W'(vcnt_q) : '0;
    end
  end

  always_ff @(posedge pxclk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      sync_q <= SYNC_IDLE;
      col_q  <= '0;
      lin_q  <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      sync_q <= sync_d;
      col_q  <= col_d;
      lin_q  <= lin_d;
    end
  end

  sync_delay #(
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk_i  (pxclk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .din_i  (sync_q),
    .dout_o (sync_dly)
  );

  assign hsync_o = sync_dly.hsync;
  assign vsync_o = sync_dly.vsync;
  assign de_o    = sync_dly.de;
  assign sof_o   = sync_dly.sof;
  assign col_o   = col_q;
  assign lin_o   = lin_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: default horizontal timing with a short frame,
// plus a tiny high-polarity configuration with a 2-stage sync delay.
module tb_lcd_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        sof;
    logic [15:0] col;
    logic [15:0] lin;
  } exp_t;

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    bit hpol, vpol;
    int dly;
  } cfg_t;

  typedef struct {
    int   inst;
    exp_t e;
  } sb_t;

  typedef struct {
    logic rst;
    logic en;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  logic       a_hs, a_vs, a_de, a_sof;
  logic [8:0] a_col, a_lin;
  logic       b_hs, b_vs, b_de, b_sof;
  logic [1:0] b_col, b_lin;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .V_ACTIVE (6),
    .V_FP     (2),
    .V_SYNC   (3),
    .V_BP     (2)
  ) dut_a (
    .pxclk_i (clk),
    .rst_i   (rst),
    .en_i    (en),
    .hsync_o (a_hs),
    .vsync_o (a_vs),
    .de_o    (a_de),
    .col_o   (a_col),
    .lin_o   (a_lin),
    .sof_o   (a_sof)
  );

  lcd_timing_gen #(
    .H_ACTIVE (4),
    .H_FP     (1),
    .H_SYNC   (2),
    .H_BP     (1),
    .V_ACTIVE (3),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b1),
    .PIPE_DLY (2),
    .COL_W    (2),
    .LIN_W    (2)
  ) dut_b (
    .pxclk_i (clk),
    .rst_i   (rst),
    .en_i    (en),
    .hsync_o (b_hs),
    .vsync_o (b_vs),
    .de_o    (b_de),
    .col_o   (b_col),
    .lin_o   (b_lin),
    .sof_o   (b_sof)
  );

  int   checks   = 0;
  int   failures = 0;
  cfg_t cfg [2];
  int   kk  [2];
  sb_t  sb [$];
  int   cyc = 0;

  // line/frame measurements on dut_a (only while meas_on)
  bit meas_on = 0;
  logic p_de = 0, p_hs = 1, p_vs = 1, p_sof = 0, pb_sof = 0;
  int de_rise = -1, hs_fall = -1, vs_fall = -1, sof_last = -1, b_sof_last = -1;
  int line_per = -1, de_len = -1, hs_off = -1, hs_len = -1;
  int vs_off = -1, vs_len = -1, sof_per = -1, b_sof_per = -1, sof_cnt = 0;
  int lin_max = 0;

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_exp(input string name, input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual{hs,vs,de,sof,col,lin}=%b%b%b%b,%0d,%0d required=%b%b%b%b,%0d,%0d",
               name, act.hs, act.vs, act.de, act.sof, act.col, act.lin,
               req.hs, req.vs, req.de, req.sof, req.col, req.lin);
    end
  endtask

  // Expected outputs after k enabled edges since reset, from the pixel index.
  function automatic exp_t model(input int i, input int k);
    exp_t e;
    cfg_t c;
    int ht, vt, p, h, v;
    c = cfg[i];
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    e.hs = ~c.hpol; e.vs = ~c.vpol; e.de = 1'b0; e.sof = 1'b0;
    e.col = '0; e.lin = '0;
    if (k > 0) begin
      p = (k - 1) % (ht * vt);
      h = p % ht; v = p / ht;
      if (h < c.ha && v < c.va) begin
        e.col = 16'(h);
        e.lin = 16'(v);
      end
      if (k - 1 - c.dly >= 0) begin
        p = (k - 1 - c.dly) % (ht * vt);
        h = p % ht; v = p / ht;
        e.de  = (h < c.ha) && (v < c.va);
        e.sof = (p == 0);
        e.hs  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
        e.vs  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
      end
    end
    return e;
  endfunction

  function automatic exp_t act_of(input int i);
    exp_t e;
    if (i == 0) e = '{hs: a_hs, vs: a_vs, de: a_de, sof: a_sof, col: 16'(a_col), lin: 16'(a_lin)};
    else        e = '{hs: b_hs, vs: b_vs, de: b_de, sof: b_sof, col: 16'(b_col), lin: 16'(b_lin)};
    return e;
  endfunction

  task automatic monitor();
    if (meas_on) begin
      if (a_de && !p_de) begin
        if (de_rise >= 0 && line_per < 0) line_per = cyc - de_rise;
        de_rise = cyc;
      end
      if (!a_de && p_de && de_rise >= 0 && de_len < 0) de_len = cyc - de_rise;
      if (!a_hs && p_hs && de_rise >= 0 && hs_off < 0) begin
        hs_off  = cyc - de_rise;
        hs_fall = cyc;
      end
      if (a_hs && !p_hs && hs_fall >= 0 && hs_len < 0) hs_len = cyc - hs_fall;
      if (a_sof && !p_sof) begin
        if (sof_last >= 0) sof_per = cyc - sof_last;
        sof_last = cyc;
        sof_cnt++;
      end
      if (!a_vs && p_vs && sof_last >= 0 && vs_off < 0) begin
        vs_off  = cyc - sof_last;
        vs_fall = cyc;
      end
      if (a_vs && !p_vs && vs_fall >= 0 && vs_len < 0) vs_len = cyc - vs_fall;
      if (b_sof && !pb_sof) begin
        if (b_sof_last >= 0 && b_sof_per < 0) b_sof_per = cyc - b_sof_last;
        b_sof_last = cyc;
      end
      if (int'(a_lin) > lin_max) lin_max = int'(a_lin);
    end
    p_de = a_de; p_hs = a_hs; p_vs = a_vs; p_sof = a_sof; pb_sof = b_sof;
  endtask

  // Drive one clock: push expectations at drive time, pop and compare after the edge.
  task automatic step(input logic r, input logic e);
    sb_t s;
    @(negedge clk);
    rst = r;
    en  = e;
    if (r) begin
      kk[0] = 0; kk[1] = 0;
    end else if (e) begin
      kk[0]++; kk[1]++;
    end
    for (int i = 0; i < 2; i++) sb.push_back('{inst: i, e: model(i, kk[i])});
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      check_exp($sformatf("dut%0d_cyc%0d", s.inst, cyc), act_of(s.inst), s.e);
    end
    monitor();
  endtask

  vec_t tbl [14];
  bit   found;

  initial begin
    cfg[0] = '{480, 2, 41, 2, 6, 2, 3, 2, 1'b0, 1'b0, 0};
    cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 2};
    kk[0] = 0; kk[1] = 0;

    // dut_b vectors: {rst, en, {hs, vs, de, sof, col, lin}}
    tbl[0]  = '{1'b1, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0}};
    tbl[1]  = '{1'b1, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0}};
    tbl[2]  = '{1'b0, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0}};
    tbl[3]  = '{1'b0, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0}};
    tbl[4]  = '{1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd0}};
    tbl[5]  = '{1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd0}};
    tbl[6]  = '{1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd0}};
    tbl[7]  = '{1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0}};
    tbl[8]  = '{1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0}};
    tbl[9]  = '{1'b0, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0}};
    tbl[10] = '{1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0}};
    tbl[11] = '{1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1}};
    tbl[12] = '{1'b0, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1}};
    tbl[13] = '{1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 16'd1}};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].en);
      check_exp($sformatf("vec%0d", i), act_of(1), tbl[i].e);
      if (i == 1) begin
        check_exp("a_reset", act_of(0), '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0});
      end
      if (i == 2) begin
        check_exp("a_first_px", act_of(0), '{1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0});
      end
    end

    // Two full frames of free-running timing.
    meas_on = 1;
    for (int i = 0; i < 13700; i++) step(1'b0, 1'b1);
    check_int("line_period", line_per, 525);
    check_int("de_len", de_len, 480);
    check_int("hs_offset", hs_off, 482);
    check_int("hs_len", hs_len, 41);
    check_int("sof_period", sof_per, 6825);
    check_int("vs_offset", vs_off, 8 * 525);
    check_int("vs_len", vs_len, 3 * 525);
    check_int("lin_max", lin_max, 5);
    check_int("b_sof_period", b_sof_per, 48);

    // Stall at col 100 for 7 clocks.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1'b0, 1'b1);
      if (a_col == 9'd100) found = 1;
    end
    check_int("reach_col100", int'(found), 1);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0);
      check_int("stall_col", int'(a_col), 100);
    end
    step(1'b0, 1'b1);
    check_int("resume_col", int'(a_col), 101);
    begin
      int cnt0;
      cnt0  = sof_cnt;
      found = 0;
      for (int i = 0; i < 8000 && !found; i++) begin
        step(1'b0, 1'b1);
        if (sof_cnt != cnt0) found = 1;
      end
      check_int("reach_sof", int'(found), 1);
      check_int("stall_sof_period", sof_per, 6825 + 7);
    end

    // Asynchronous reset in the middle of a frame.
    found = 0;
    for (int i = 0; i < 8000 && !found; i++) begin
      step(1'b0, 1'b1);
      if (a_lin == 9'd3) found = 1;
    end
    check_int("reach_lin3", int'(found), 1);
    #2;
    rst = 1'b1;
    kk[0] = 0; kk[1] = 0;
    #1;
    check_exp("a_async_rst", act_of(0), '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0});
    check_exp("b_async_rst", act_of(1), '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0});
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check_int("restart_de", int'(a_de), 1);
    check_int("restart_sof", int'(a_sof), 1);
    check_int("restart_col", int'(a_col), 0);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Parametrised raster timing generator for parallel RGB/DPI LCD panels.
- Both horizontal and vertical counters run in the pixel clock domain; the vertical counter is not clocked from hsync.
- Produces hsync, vsync, DE, column/line coordinates and a start-of-frame strobe.
- Optional sync/DE delay re-aligns the syncs with a pipelined pixel path. Sits between the PLL pixel clock and the pattern/colour logic.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, hsync width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, vsync width (lines)
- V_BP, 2, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active low)
- VS_POL, 0, vsync active level
- PIPE_DLY, 0, extra clocks of delay on hsync/vsync/de/sof relative to col/lin (0..15)
- COL_W, 9, col_o width; must satisfy 2^COL_W >= H_ACTIVE
- LIN_W, 9, lin_o width; must satisfy 2^LIN_W >= V_ACTIVE

Ports:
- pxclk_i  in  1  pixel clock, sole clock
- rst_i  in  1  asynchronous reset, active high
- en_i  in  1  clock enable; low freezes all state
- hsync_o  out  1  horizontal sync, polarity per HS_POL
- vsync_o  out  1  vertical sync, polarity per VS_POL
- de_o  out  1  data enable (hactive & vactive)
- col_o  out  COL_W  pixel column, 0 outside active area
- lin_o  out  LIN_W  pixel line, 0 outside active area
- sof_o  out  1  one-clock pulse at pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 525); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 286).
- Internal counters: hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1, each sized with clog2 of its total.
- Counter updates only on clock edges with en_i=1.
- hcnt wraps H_TOTAL-1 -> 0. vcnt increments only on that same wrap and wraps V_TOTAL-1 -> 0.
- Region order, horizontal and vertical alike: active, FP, SYNC, BP.
  - hactive = hcnt < H_ACTIVE
  - hsync active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC
  - vactive and vsync decoded the same way from vcnt
  - vsync transitions coincide with hcnt=0.
- All outputs are registered: outputs at edge n+1 reflect counter state at edge n (1-clock latency).
- col_o = hcnt and lin_o = vcnt when active, else 0.
- sof_o = 1 iff hcnt=0 and vcnt=0.
- PIPE_DLY > 0: hsync/vsync/de/sof pass through a PIPE_DLY-stage shift register.
  - The shift register is enabled by en_i.
  - Stages reset to inactive values.
  - col_o/lin_o are not delayed.
- Reset (asynchronous, any time, including mid-frame):
  - hcnt = vcnt = 0
  - hsync_o = ~HS_POL, vsync_o = ~VS_POL
  - de_o = 0, col_o = 0, lin_o = 0, sof_o = 0
  - all delay stages cleared.
- After reset deasserts, the first enabled edge presents pixel (0,0): de_o=1 and sof_o=1 (PIPE_DLY=0).
- en_i low: counters, output registers and delay line hold their values. Outputs stay static; sof_o may therefore stay high across stalled cycles.
- Elaboration-time checks (generate-time error): each porch/sync parameter >= 1; H_ACTIVE and V_ACTIVE >= 1; PIPE_DLY <= 15.

Decomposition:
- Package lcd_timing_pkg:
  - default 480x272 timing constants (H_*/V_* values above)
  - polarity constants POL_LOW=0 and POL_HIGH=1
  - clog2 function
  - a second preset for 800x480 panels
- One sub-module, sync_delay: parametrised depth, width 4, clock enable, async reset to a parametrised reset vector; pass-through when depth 0.
- The top module holds the counters and region decode.

Test Plan:
- Reset check: hold rst_i with en_i=1 -> hsync_o=1, vsync_o=1, de_o=0, col_o=0, lin_o=0, sof_o=0. Release -> next edge de_o=1, sof_o=1, col_o=0.
- Default line timing:
  - de_o high exactly 480 clocks per line, col_o running 0..479
  - hsync_o low 41 clocks, starting 482 clocks after the line's first DE
  - line period 525 clocks.
- Default frame timing:
  - sof_o period 150150 clocks
  - vsync_o low for 10 lines starting at line 274, edges aligned with hcnt=0
  - de_o never high outside lines 0..271; lin_o reaches 271.
- Small config (H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1, PIPE_DLY=2):
  - frame = 48 clocks
  - hsync_o high 2 clocks per line
  - de_o and sof_o lag col_o/lin_o by exactly 2 clocks.
- Stall: drop en_i for 7 clocks at col_o=100 -> all outputs frozen. On resume col_o=101, and sof spacing grows by exactly 7.
- Mid-frame reset: assert rst_i asynchronously at line 150 (between clock edges) -> outputs go to reset values immediately. After release the frame restarts at (0,0) with sof_o=1.
